mod_n_digit_counter: RTL and testbench
======================================

# mod_n_digit_counter

Synchronous, parametrised multi-digit modulo-N counter that generalises the team's ripple decade counter into a single-clock design. It supports configurable digit count and per-digit radix, up/down counting, parallel load, count enable, and a terminal-count, carry and sticky-overflow indication. It is the standard counter for display, timebase and event-count paths; carry_out chains into further instances.

## Interface
Parameters:
- DIGITS, default 4: number of cascaded digits, 1..8.
- MODULUS, default 10: radix of every digit, 2..16.

Ports:
- clk  input  1  rising-edge clock; only clock in the block.
- reset  input  1  reset is synchronous and active-high.
- en  input  1  count enable; one step per clk edge while high.
- up  input  1  1 = count up, 0 = count down; sampled with en.
- load  input  1  parallel load strobe.
- load_val  input  4*DIGITS  load value; digit k in bits [4k+3:4k].
- ovf_clr  input  1  clears ovf.
- q  output  4*DIGITS  registered count; digit k in bits [4k+3:4k], digit 0 least significant.
- tc  output  1  terminal count, combinational: all digits MODULUS-1 when up=1, all digits 0 when up=0.
- carry_out  output  1  registered one-cycle pulse on whole-counter wrap.
- ovf  output  1  sticky wrap flag.

## Operation
- Priority on each clk edge: reset > load > en. Idle (none asserted): all state holds.
- reset: q=0, carry_out=0, ovf=0.
- load: each digit takes its load_val digit. A digit value >= MODULUS saturates to MODULUS-1. carry_out=0. ovf is unaffected except by ovf_clr.
- Count up: digit 0 increments. Digit k steps when en=1 and all lower digits are MODULUS-1. MODULUS-1 wraps to 0.
- Count down: digit 0 decrements. Digit k steps when en=1 and all lower digits are 0. 0 wraps to MODULUS-1.
- Whole-counter wrap means en=1 and tc=1 at the edge (up: all-max -> 0; down: 0 -> all-max). On wrap, carry_out=1 for exactly the following cycle and ovf is set.
- ovf_clr=1 clears ovf. If a wrap and ovf_clr occur in the same cycle, set wins and ovf=1.
- up may change any cycle. The direction applied is the value sampled at the edge.
- Digit bits of q are never >= MODULUS in any reachable state.

## Timing
- q latency: 1 cycle from an en/load/reset edge to the updated value; no multi-cycle ripple.
- tc is combinational from q and up; there is no clock-to-tc register.
- carry_out is high in the cycle after the wrapping edge, together with the wrapped q.
- Reset mid-count, even with load and en high, yields q=0 on the next cycle.
- Back-to-back en: one count per cycle with no bubbles.

## Structure
- Shared package mod_counter_pkg:
  - DIGIT_W=4
  - MAX_DIGITS=8
  - function digit_sat(value, modulus) for load clamping.
- One sub-module, mod_digit: a 4-bit cell with inputs step, up, load, load_digit and output digit. It wraps at MODULUS and its combinational outputs at_max/at_zero feed the enable chain.
- The top level instantiates DIGITS cells via generate and holds the carry_out and ovf registers.

## Test plan
- Reset then en=1, up=1 for 10000 cycles (defaults) -> q steps 0000..9999 then 0000. tc is high only at 9999. carry_out pulses once, the cycle q=0000. ovf=1.
- From reset, en=1, up=0 for 1 cycle -> q=9999, carry_out=1 next cycle. A further 3 cycles -> q=9996.
- Count to 0123, pulse load with load_val=0x4F57 -> q=4957 next cycle (F saturates to 9). The count resumes from 4957.
- At q=9999 with en=1 and up=1, assert ovf_clr the same cycle -> ovf=1. ovf_clr alone next cycle -> ovf=0.
- With en=1 and load=1 at q=0500, assert reset -> q=0000, carry_out=0, ovf=0.
- DIGITS=2, MODULUS=6, en=1, up=1 for 36 cycles from reset -> q visits 00..55 in radix-6 order, wraps to 00 with one carry_out pulse.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the multi-digit modulo-N counter.
package mod_counter_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  // Clamp a loaded digit into the legal range 0..modulus-1.
  function automatic logic [DIGIT_W-1:0] digit_sat(input logic [DIGIT_W-1:0] value,
                                                   input int modulus);
    logic [DIGIT_W-1:0] res;
    if (int'(value) >= modulus) begin
      res = DIGIT_W'(modulus - 1);
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_digit.sv
// Single 4-bit modulo-MODULUS digit cell with load, up/down step and range flags.
module mod_digit
  import mod_counter_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               up,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_max,
  output logic               at_zero
);

  localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  assign at_max  = (digit_q == MAX_VAL);
  assign at_zero = (digit_q == {DIGIT_W{1'b0}});
  assign digit   = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = digit_sat(load_digit, MODULUS);
    end else if (step) begin
      if (up) begin
        digit_d = at_max ? {DIGIT_W{1'b0}} : digit_q + 4'd1;
      end else begin
        digit_d = at_zero ? MAX_VAL : digit_q - 4'd1;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= {DIGIT_W{1'b0}};
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/mod_n_digit_counter.sv
// Single-clock cascaded modulo-N counter: DIGITS cells of radix MODULUS, with
// terminal count, one-cycle carry pulse on whole-counter wrap and sticky overflow.
module mod_n_digit_counter
  import mod_counter_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      up,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  input  logic                      ovf_clr,
  output logic [DIGIT_W*DIGITS-1:0] q,
  output logic                      tc,
  output logic                      carry_out,
  output logic                      ovf
);

  logic [DIGITS-1:0] at_max_s;
  logic [DIGITS-1:0] at_zero_s;
  logic [DIGITS-1:0] step_s;
  logic              wrap_s;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    // A digit steps only when every lower digit is at its rollover value.
    localparam logic [DIGITS-1:0] LOWER = DIGITS'((1 << k) - 1);

    assign step_s[k] = en & (up ? ((at_max_s & LOWER) == LOWER)
                                : ((at_zero_s & LOWER) == LOWER));

    mod_digit #(.MODULUS(MODULUS)) u_digit (
      .clk        (clk),
      .reset      (reset),
      .step       (step_s[k]),
      .up         (up),
      .load       (load),
      .load_digit (load_val[DIGIT_W*k +: DIGIT_W]),
      .digit      (q[DIGIT_W*k +: DIGIT_W]),
      .at_max     (at_max_s[k]),
      .at_zero    (at_zero_s[k])
    );
  end

  always_comb begin
    if (up) begin
      tc = &at_max_s;
    end else begin
      tc = &at_zero_s;
    end
  end

  // Load takes priority over counting, so a wrap cannot coincide with a load.
  assign wrap_s = en & tc & ~load;

  always_comb begin
    carry_d = wrap_s;
    ovf_d   = ovf_q;
    if (wrap_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign carry_out = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mod_n_digit_counter.sv
// Scoreboard bench: two counter instances (4x mod-10, 2x mod-6) share stimulus and
// are checked against an integer-valued reference model.
module tb_mod_n_digit_counter;

  logic        clk = 1'b0;
  logic        reset, en, up, load, ovf_clr;
  logic [15:0] load_val;
  logic [15:0] q1;
  logic        tc1, co1, ovf1;
  logic [7:0]  q2;
  logic        tc2, co2, ovf2;

  always #5 clk = ~clk;

  mod_n_digit_counter #(.DIGITS(4), .MODULUS(10)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr),
    .q(q1), .tc(tc1), .carry_out(co1), .ovf(ovf1)
  );

  mod_n_digit_counter #(.DIGITS(2), .MODULUS(6)) dut2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[7:0]), .ovf_clr(ovf_clr),
    .q(q2), .tc(tc2), .carry_out(co2), .ovf(ovf2)
  );

  typedef struct {
    logic [31:0] q;
    logic        tc;
    logic        co;
    logic        ovf;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];

  int n_vec = 0;
  int n_bad = 0;

  int digs[2] = '{4, 2};
  int mods[2] = '{10, 6};
  int m_val[2];
  bit m_ovf[2];
  bit m_carry[2];

  function automatic int total_of(input int i);
    int t = 1;
    for (int k = 0; k < digs[i]; k++) t = t * mods[i];
    return t;
  endfunction

  // Counter value (plain integer) -> packed per-digit nibbles.
  function automatic logic [31:0] encode(input int i, input int v);
    logic [31:0] r = 32'd0;
    int p = 1;
    for (int k = 0; k < digs[i]; k++) begin
      r = r | (32'((v / p) % mods[i]) << (4 * k));
      p = p * mods[i];
    end
    return r;
  endfunction

  function automatic int load_value(input int i, input logic [15:0] lv);
    int s = 0;
    int p = 1;
    for (int k = 0; k < digs[i]; k++) begin
      int d = int'((lv >> (4 * k)) & 16'h000F);
      if (d >= mods[i]) d = mods[i] - 1;
      s = s + d * p;
      p = p * mods[i];
    end
    return s;
  endfunction

  task automatic model(input int i, input bit r, input bit l, input logic [15:0] lv,
                       input bit e, input bit u, input bit c, output exp_t x);
    int tot = total_of(i);
    bit wrap;
    if (r) begin
      m_val[i] = 0; m_carry[i] = 1'b0; m_ovf[i] = 1'b0;
    end else if (l) begin
      m_val[i] = load_value(i, lv); m_carry[i] = 1'b0;
      if (c) m_ovf[i] = 1'b0;
    end else if (e) begin
      wrap = u ? (m_val[i] == tot - 1) : (m_val[i] == 0);
      m_val[i] = u ? (m_val[i] + 1) % tot : (m_val[i] + tot - 1) % tot;
      m_carry[i] = wrap;
      if (wrap) m_ovf[i] = 1'b1;
      else if (c) m_ovf[i] = 1'b0;
    end else begin
      m_carry[i] = 1'b0;
      if (c) m_ovf[i] = 1'b0;
    end
    x.q   = encode(i, m_val[i]);
    x.co  = m_carry[i];
    x.ovf = m_ovf[i];
    x.tc  = u ? (m_val[i] == tot - 1) : (m_val[i] == 0);
  endtask

  task automatic drive(input bit r, input bit l, input logic [15:0] lv,
                       input bit e, input bit u, input bit c);
    exp_t x;
    @(negedge clk);
    reset = r; load = l; load_val = lv; en = e; up = u; ovf_clr = c;
    model(0, r, l, lv, e, u, c, x); sb1.push_back(x);
    model(1, r, l, lv, e, u, c, x); sb2.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every cycle after the edge, compare against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb1.size() > 0) begin
        x = sb1.pop_front();
        chk("d1.q",   {16'd0, q1}, x.q);
        chk("d1.tc",  {31'd0, tc1}, {31'd0, x.tc});
        chk("d1.co",  {31'd0, co1}, {31'd0, x.co});
        chk("d1.ovf", {31'd0, ovf1}, {31'd0, x.ovf});
      end
      if (sb2.size() > 0) begin
        x = sb2.pop_front();
        chk("d2.q",   {24'd0, q2}, x.q);
        chk("d2.tc",  {31'd0, tc2}, {31'd0, x.tc});
        chk("d2.co",  {31'd0, co2}, {31'd0, x.co});
        chk("d2.ovf", {31'd0, ovf2}, {31'd0, x.ovf});
      end
    end
  end

  initial begin
    logic [15:0] lv;
    bit r, l, e, u, c;
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'd0; ovf_clr = 1'b0;

    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    // Full up sweep through 9999 -> 0000 (dut2 wraps every 36 cycles).
    repeat (10000) drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Down from zero wraps to all-max, then three more steps.
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Count to 0123, then load with a saturating nibble, then resume.
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (123) drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 16'h4F57, 1'b1, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    // Wrap and ovf_clr together: set wins; then clear alone.
    drive(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Reset beats load and en.
    drive(1'b0, 1'b1, 16'h0500, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);

    repeat (4000) begin
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 1) == 1);
      c  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       lv = 16'h9999;
        1:       lv = 16'h0000;
        2:       lv = 16'hFFFF;
        default: lv = 16'($urandom);
      endcase
      drive(r, l, lv, e, u, c);
    end

    for (int k = 0; k < 20 && (sb1.size() > 0 || sb2.size() > 0); k++) @(posedge clk);
    #2;
    if (sb1.size() > 0 || sb2.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb1.size() + sb2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
